// File: rtl/dac_output_sequencer.sv
// Two-channel DAC output sequencer: reset holdoff, per-channel source select,
// slew-limited outputs and a ramp-to-zero on fault or disable.
module dac_output_sequencer #(
  parameter int DATA_WIDTH = 14,
  parameter int HOLDOFF    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fault_i,
  input  logic                  src_sel,
  input  logic [DATA_WIDTH-1:0] servo_a,
  input  logic [DATA_WIDTH-1:0] servo_b,
  input  logic                  servo_valid,
  input  logic [DATA_WIDTH-1:0] sweep_a,
  input  logic [DATA_WIDTH-1:0] sweep_b,
  input  logic                  sweep_valid,
  input  logic [DATA_WIDTH-1:0] slew_max,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  dac_rst_req,
  output logic [1:0]            state_o,
  output logic                  tripped
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    IDLE   = 2'd1,
    RUN    = 2'd2,
    RAMPDN = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   tgt_a, tgt_b, tgt_a_nxt, tgt_b_nxt;
  logic [DW-1:0]   dout_a_nxt, dout_b_nxt;
  logic            tripped_nxt;

  // One slew-limited step from cur toward tgt; the result never passes tgt,
  // so the DW-bit add/subtract cannot wrap.
  function automatic logic [DW-1:0] step(input logic [DW-1:0] cur,
                                         input logic [DW-1:0] tgt,
                                         input logic [DW-1:0] slew);
    logic signed [DW:0] diff;
    logic [DW:0]        mag;
    logic [DW-1:0]      res;
    diff = $signed({tgt[DW-1], tgt}) - $signed({cur[DW-1], cur});
    mag  = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
    if (slew == '0 || mag <= {1'b0, slew})
      res = tgt;
    else if (diff[DW])
      res = cur - slew;
    else
      res = cur + slew;
    return res;
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tgt_a_nxt   = tgt_a;
    tgt_b_nxt   = tgt_b;
    dout_a_nxt  = dout_a;
    dout_b_nxt  = dout_b;
    tripped_nxt = tripped;
    case (state)
      HOLD: begin
        tgt_a_nxt  = '0;
        tgt_b_nxt  = '0;
        dout_a_nxt = '0;
        dout_b_nxt = '0;
        if (cnt == CW'(HOLDOFF - 1))
          state_nxt = IDLE;
        else
          cnt_nxt = cnt + CW'(1);
      end
      IDLE: begin
        tgt_a_nxt  = '0;
        tgt_b_nxt  = '0;
        dout_a_nxt = '0;
        dout_b_nxt = '0;
        if (enable && !fault_i) begin
          state_nxt   = RUN;
          tripped_nxt = 1'b0;
        end
      end
      RUN: begin
        // Outputs step toward the registered target, giving two-cycle latency.
        dout_a_nxt = step(dout_a, tgt_a, slew_max);
        dout_b_nxt = step(dout_b, tgt_b, slew_max);
        if (!src_sel && servo_valid) begin
          tgt_a_nxt = servo_a;
          tgt_b_nxt = servo_b;
        end else if (src_sel && sweep_valid) begin
          tgt_a_nxt = sweep_a;
          tgt_b_nxt = sweep_b;
        end
        if (fault_i) begin
          state_nxt   = RAMPDN;
          tripped_nxt = 1'b1;
          tgt_a_nxt   = '0;
          tgt_b_nxt   = '0;
        end else if (!enable) begin
          state_nxt = RAMPDN;
          tgt_a_nxt = '0;
          tgt_b_nxt = '0;
        end
      end
      RAMPDN: begin
        tgt_a_nxt  = '0;
        tgt_b_nxt  = '0;
        dout_a_nxt = step(dout_a, '0, slew_max);
        dout_b_nxt = step(dout_b, '0, slew_max);
        if (dout_a == '0 && dout_b == '0)
          state_nxt = IDLE;
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      cnt         <= '0;
      tgt_a       <= '0;
      tgt_b       <= '0;
      dout_a      <= '0;
      dout_b      <= '0;
      dac_rst_req <= 1'b1;
      tripped     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tgt_a       <= tgt_a_nxt;
      tgt_b       <= tgt_b_nxt;
      dout_a      <= dout_a_nxt;
      dout_b      <= dout_b_nxt;
      dac_rst_req <= (state_nxt == HOLD);
      tripped     <= tripped_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_dac_output_sequencer.sv
// Directed, table-driven bench for dac_output_sequencer with HOLDOFF=16.
module tb_dac_output_sequencer;

  localparam int DW = 14;
  localparam int HO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0, fault_i = 1'b0, src_sel = 1'b0;
  logic [DW-1:0] servo_a = '0, servo_b = '0, sweep_a = '0, sweep_b = '0, slew_max = '0;
  logic          servo_valid = 1'b0, sweep_valid = 1'b0;
  logic [DW-1:0] dout_a, dout_b;
  logic          dac_rst_req, tripped;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;

  dac_output_sequencer #(.DATA_WIDTH(DW), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fault_i(fault_i), .src_sel(src_sel),
    .servo_a(servo_a), .servo_b(servo_b), .servo_valid(servo_valid),
    .sweep_a(sweep_a), .sweep_b(sweep_b), .sweep_valid(sweep_valid),
    .slew_max(slew_max), .dout_a(dout_a), .dout_b(dout_b),
    .dac_rst_req(dac_rst_req), .state_o(state_o), .tripped(tripped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, flt, sel, sv, wv;
    int   sa, sb, wa, wb, slew;
    int   ea, eb, est, etr;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t mk(input logic en, input logic flt, input logic sel,
                              input logic sv, input int sa, input int sb,
                              input logic wv, input int wa, input int wb,
                              input int slew, input int ea, input int eb,
                              input int est, input int etr);
    vec_t v;
    v.en = en; v.flt = flt; v.sel = sel; v.sv = sv; v.sa = sa; v.sb = sb;
    v.wv = wv; v.wa = wa; v.wb = wb; v.slew = slew;
    v.ea = ea; v.eb = eb; v.est = est; v.etr = etr;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sa_of(input logic [DW-1:0] d);
    return int'($signed(d));
  endfunction

  // Each row: inputs driven at a falling edge, outputs checked one rising edge later.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      enable      = rows[i].en;
      fault_i     = rows[i].flt;
      src_sel     = rows[i].sel;
      servo_valid = rows[i].sv;
      servo_a     = DW'(rows[i].sa);
      servo_b     = DW'(rows[i].sb);
      sweep_valid = rows[i].wv;
      sweep_a     = DW'(rows[i].wa);
      sweep_b     = DW'(rows[i].wb);
      slew_max    = DW'(rows[i].slew);
      @(negedge clk);
      check($sformatf("row%0d dout_a", i), sa_of(dout_a), rows[i].ea);
      check($sformatf("row%0d dout_b", i), sa_of(dout_b), rows[i].eb);
      check($sformatf("row%0d state", i), int'(state_o), rows[i].est);
      check($sformatf("row%0d tripped", i), int'(tripped), rows[i].etr);
    end
  endtask

  task automatic hold_sequence(input string tag);
    for (int i = 1; i <= HO; i++) begin
      @(negedge clk);
      check($sformatf("%s rst_req edge%0d", tag, i), int'(dac_rst_req), (i < HO) ? 1 : 0);
      check($sformatf("%s state edge%0d", tag, i), int'(state_o), (i < HO) ? 0 : 1);
      check($sformatf("%s dout_a edge%0d", tag, i), sa_of(dout_a), 0);
      check($sformatf("%s dout_b edge%0d", tag, i), sa_of(dout_b), 0);
    end
  endtask

  initial begin
    int s1, s2, s3, s4, ea;

    // Plain bring-up, slew up and the start of a long slew down.
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,       0,    0,    0,2,0));
    rows.push_back(mk(1,0,0, 1,1000,-2000,  0,0,0,       0,    0,    0,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,       0, 1000,-2000,2,0));
    rows.push_back(mk(1,0,0, 1,0,0,         0,0,0,       0, 1000,-2000,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,       0,    0,    0,2,0));
    rows.push_back(mk(1,0,0, 1,350,0,       0,0,0,     100,    0,    0,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     100,  100,    0,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     100,  200,    0,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     100,  300,    0,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     100,  350,    0,2,0));
    rows.push_back(mk(1,0,0, 1,-8192,0,     0,0,0,     100,  350,    0,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     100,  250,    0,2,0));
    s1 = rows.size();
    // Fault ramp-down from 1000/-1000, then automatic restart.
    rows.push_back(mk(1,0,0, 1,1000,-1000,  0,0,0,       0,-8192,    0,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,       0, 1000,-1000,2,0));
    rows.push_back(mk(1,1,0, 0,0,0,         0,0,0,     300, 1000,-1000,3,1));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     300,  700, -700,3,1));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     300,  400, -400,3,1));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     300,  100, -100,3,1));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     300,    0,    0,3,1));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     300,    0,    0,1,1));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     300,    0,    0,2,0));
    s2 = rows.size();
    // Source switch, disable ramp, fault held in IDLE, fault/disable priority.
    rows.push_back(mk(1,0,0, 1,500,500,     1,-500,-500, 0,    0,    0,2,0));
    rows.push_back(mk(1,0,0, 1,500,500,     1,-500,-500, 0,  500,  500,2,0));
    rows.push_back(mk(1,0,1, 1,500,500,     1,-500,-500,250, 500,  500,2,0));
    rows.push_back(mk(1,0,1, 1,500,500,     0,0,0,     250,  250,  250,2,0));
    rows.push_back(mk(1,0,1, 1,500,500,     0,0,0,     250,    0,    0,2,0));
    rows.push_back(mk(1,0,1, 1,500,500,     0,0,0,     250, -250, -250,2,0));
    rows.push_back(mk(1,0,1, 1,500,500,     0,0,0,     250, -500, -500,2,0));
    rows.push_back(mk(1,0,1, 1,500,500,     0,0,0,     250, -500, -500,2,0));
    rows.push_back(mk(0,0,0, 0,0,0,         0,0,0,     250, -500, -500,3,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     250, -250, -250,3,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     250,    0,    0,3,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     250,    0,    0,1,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     250,    0,    0,2,0));
    rows.push_back(mk(0,0,0, 0,0,0,         0,0,0,     250,    0,    0,3,0));
    rows.push_back(mk(1,1,0, 0,0,0,         0,0,0,     250,    0,    0,1,0));
    rows.push_back(mk(1,1,0, 0,0,0,         0,0,0,     250,    0,    0,1,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,     250,    0,    0,2,0));
    rows.push_back(mk(0,1,0, 0,0,0,         0,0,0,     250,    0,    0,3,1));
    rows.push_back(mk(0,0,0, 0,0,0,         0,0,0,     250,    0,    0,1,1));
    s3 = rows.size();
    // Set up a fault ramp at 600 for the asynchronous reset.
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,       0,    0,    0,2,0));
    rows.push_back(mk(1,0,0, 1,600,0,       0,0,0,       0,    0,    0,2,0));
    rows.push_back(mk(1,0,0, 0,0,0,         0,0,0,       0,  600,    0,2,0));
    rows.push_back(mk(1,1,0, 0,0,0,         0,0,0,     100,  600,    0,3,1));
    s4 = rows.size();

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset dout_a", sa_of(dout_a), 0);
    check("reset dout_b", sa_of(dout_b), 0);
    check("reset rst_req", int'(dac_rst_req), 1);
    check("reset state", int'(state_o), 0);
    check("reset tripped", int'(tripped), 0);
    rst = 1'b0;
    hold_sequence("hold1");

    run_rows(0, s1);
    ea = 250;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      ea = (ea - 100 < -8192) ? -8192 : ea - 100;
      check($sformatf("slewdown step%0d", k), sa_of(dout_a), ea);
    end
    check("slewdown dout_b", sa_of(dout_b), 0);

    run_rows(s1, s2);
    run_rows(s2, s3);
    run_rows(s3, s4);

    #2 rst = 1'b1;
    #1;
    check("async dout_a", sa_of(dout_a), 0);
    check("async dout_b", sa_of(dout_b), 0);
    check("async rst_req", int'(dac_rst_req), 1);
    check("async state", int'(state_o), 0);
    check("async tripped", int'(tripped), 0);
    @(negedge clk);
    enable = 1'b0;
    fault_i = 1'b0;
    rst = 1'b0;
    hold_sequence("hold2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_output_sequencer.md
# dac_output_sequencer

Sequences and arbitrates the two DAC channels ahead of the DDR DAC output stage. It selects between a servo source and a sweep source per channel. It rate-limits every output change (slew limit) and holds the DAC in reset for a fixed holdoff after system reset. On fault or disable it ramps both channels to zero before going idle. Its outputs `dout_a`, `dout_b` and `dac_rst_req` feed the output stage directly, so that stage only ever sees legal, bounded codes.

## Interface
- `DATA_WIDTH`, 14, sample width, signed two's complement.
- `HOLDOFF`, 1024, cycles `dac_rst_req` stays high after reset release; must be ≥1.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level; request to drive sources to DAC.
- `fault_i` in 1: level; forces ramp-down.
- `src_sel` in 1: 0 = servo, 1 = sweep; applies to both channels.
- `servo_a`, `servo_b` in DATA_WIDTH: servo samples.
- `servo_valid` in 1: servo samples valid this cycle.
- `sweep_a`, `sweep_b` in DATA_WIDTH: sweep samples.
- `sweep_valid` in 1: sweep samples valid this cycle.
- `slew_max` in DATA_WIDTH: unsigned max |step| per cycle; 0 = unlimited.
- `dout_a`, `dout_b` out DATA_WIDTH: registered channel codes.
- `dac_rst_req` out 1: registered; DAC stage reset request.
- `state_o` out 2: current FSM state encoding.
- `tripped` out 1: registered; last ramp-down was fault-caused.

## Operation
- **States:**
  - HOLD=0, IDLE=1, RUN=2, RAMPDN=3.
- **HOLD:**
  - Entered on reset.
  - `dac_rst_req`=1, outputs 0, holdoff counter counts 0..HOLDOFF-1.
  - Moves to IDLE on the edge where the counter reaches HOLDOFF-1.
- **IDLE:**
  - Outputs 0, `dac_rst_req`=0.
  - Moves to RUN when `enable`=1 and `fault_i`=0.
  - Entering RUN clears `tripped`.
- **RUN:**
  - Targets `tgt_a`/`tgt_b` load from the selected source on cycles where that source's valid=1.
  - Otherwise the previous target is held. The valid of the unselected source is ignored.
  - Each cycle, per channel: diff = tgt − dout, computed in DATA_WIDTH+1 signed bits.
  - If `slew_max`=0 or |diff| ≤ `slew_max`: dout ← tgt. Otherwise dout ← dout ± `slew_max` (sign of diff).
  - Result is always within [dout, tgt], so there is no overflow or wrap.
  - `src_sel` changes take effect on the next valid of the newly selected source. The transition is slew-limited like any other target change.
- **RUN exits:**
  - `fault_i`=1 → RAMPDN with `tripped`←1.
  - `enable`=0 (and `fault_i`=0) → RAMPDN with `tripped` unchanged.
  - Fault takes priority if both occur in the same cycle.
- **RAMPDN:**
  - Targets forced to 0; same slew rule toward 0.
  - Source valids and `src_sel` ignored; `fault_i` and `enable` ignored.
  - Moves to IDLE on the cycle both outputs equal 0.
  - If both are already 0 on entry, moves to IDLE after one cycle.
- On entering RUN from IDLE, targets are reset to 0, so output starts from 0 and slews to the first valid sample.

## Timing
- **Reset values:**
  - `dout_a`=`dout_b`=0, `dac_rst_req`=1, `state_o`=0, `tripped`=0.
  - Targets and counter cleared.
- **Reset assertion:** asynchronous, at any point including mid-ramp; all outputs take reset values immediately.
- **Reset release:** synchronous to `clk`. `dac_rst_req` falls after exactly HOLDOFF rising edges following the first edge with `rst`=0.
- **Latency:** a sample presented with valid in cycle n is on `dout` after the edge ending cycle n+1 (2 cycles), when within slew.
- **Ramp duration:** a ramp of magnitude M at slew S>0 takes ceil(M/S) cycles.
- **State transitions:** one edge after the triggering condition is sampled. `state_o` is the registered state.
- `enable` re-asserted during RAMPDN: the ramp completes, IDLE is held one cycle, then RUN.
- `fault_i` held high in IDLE: remains IDLE regardless of `enable`.

## Test plan
- Assert `rst` for 5 cycles, then release with HOLDOFF=16 → `dac_rst_req`=1 for exactly 16 edges after release, `state_o` 0→1, both outputs 0 throughout.
- IDLE; `enable`=1, `src_sel`=0, `slew_max`=0, servo_valid with a=1000, b=−2000 → `state_o`=2, then outputs 1000/−2000 two cycles after valid.
- RUN at 0, `slew_max`=100, servo a=350 → `dout_a` 100, 200, 300, 350 on successive cycles; then a=−8192 → decreases by 100 per cycle, no wrap, settles at −8192.
- RUN, outputs 1000/−1000, `slew_max`=300, `fault_i` pulse 1 cycle → RAMPDN: a 700, 400, 100, 0 and b −700, −400, −100, 0; `tripped`=1; IDLE after both reach 0; `enable` still 1 → RUN next cycle, `tripped`=0.
- RUN with servo=500 (valid), sweep=−500 (valid); toggle `src_sel` 0→1 with `slew_max`=250 → outputs 250, 0, −250, −500; servo valids after the switch ignored.
- Mid-ramp (RAMPDN, `dout_a`=600) assert `rst` asynchronously between edges → outputs 0, `dac_rst_req`=1, `state_o`=0 before the next edge; HOLD sequence restarts.
